modexp_mod_reducer: RTL
=======================

Name: modexp_mod_reducer

Overview:
- Sequential reduction stage directly downstream of the Karatsuba multiplier: takes the 2*WIDTH-bit product and a WIDTH-bit modulus, returns product mod modulus.
- Bit-serial restoring reduction, one product bit per cycle, MSB first. Small area, needs no divider.
- Feeds the modular-exponentiation datapath.
- Valid/ready handshakes on both sides, so the multiplier's o_finish can drive i_valid directly.

Parameters:
- WIDTH, 1024, modulus and result width in bits.
- PROD_WIDTH, 2*WIDTH, product width; must equal multiplier output width.
- CNT_WIDTH, $clog2(PROD_WIDTH), bit-counter width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset. Asynchronous, active-high.
- i_valid  input  1  product/modulus valid.
- o_ready  output  1  block can accept an operand pair.
- product_in  input  PROD_WIDTH  unsigned product, e.g. multiplier result.
- modulus_in  input  WIDTH  unsigned modulus.
- o_valid  output  1  result valid; held until consumed.
- i_ready  input  1  downstream accepts result.
- result  output  WIDTH  product_in mod modulus_in.
- o_err  output  1  with o_valid: modulus was zero.

Behaviour:
- Reset (async assert; deassert sampled on clk_in):
  - state=IDLE; o_valid=0, o_err=0, result=0.
  - Internal remainder, counter and operand registers are zeroed.
- Reset mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- o_ready = (state==IDLE), purely a function of state.
- IDLE:
  - On an edge with i_valid && o_ready, capture product_in into a shift register and modulus_in into modulus register M.
  - Clear remainder R (WIDTH+1 bits); set counter=PROD_WIDTH-1.
  - If modulus_in==0: go to DONE with result=0, o_err=1.
  - Otherwise go to RUN.
- RUN, each edge:
  - R' = (R<<1) | shift_reg MSB; shift_reg <<= 1.
  - If R' >= {1'b0,M}, R <= R' - M; else R <= R'.
  - Invariant R < M, so R' < 2M fits WIDTH+1 bits with no overflow.
  - On the edge where counter==0: result <= R[WIDTH-1:0] from this final step, o_err <= 0, go to DONE. Otherwise decrement counter.
- DONE:
  - o_valid=1; result and o_err stable.
  - On an edge with o_valid && i_ready: o_valid <= 0, go to IDLE.
- Latency: o_valid rises exactly PROD_WIDTH edges after the accepting edge, or 1 edge for a zero modulus.
- Throughput: one operation per PROD_WIDTH+2 cycles minimum. The IDLE bubble is mandatory; DONE never accepts new input.
- i_valid while o_ready=0 is ignored. The upstream must hold its data; the multiplier result is combinationally stable while its inputs are held.
- product_in < modulus_in: result equals product_in.
- modulus_in==1: result 0.
- Inputs sampled only on the accepting edge. Later changes to product_in/modulus_in do not affect the operation in flight.
- result and o_err change only on the DONE entry edge and on reset.

Decomposition:
- Shared package `modexp_pkg`:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} red_state_t.
  - Default WIDTH localparam.
- One natural combinational sub-module, `mod_cond_sub`:
  - Inputs: WIDTH+1-bit R', WIDTH-bit M.
  - Outputs: conditionally subtracted WIDTH+1-bit value.
  - Reusable by the Montgomery stage.
- FSM, counter and registers stay in modexp_mod_reducer.

Test Plan (WIDTH=8, PROD_WIDTH=16 unless noted):
- Basic: product 0x1234, modulus 0xFB, i_ready=1 → o_valid 16 edges after accept, result 0x8E, o_err=0; o_ready returns high one cycle after the result is consumed.
- Boundaries:
  - 0xFFFF mod 0xFF → 0x00.
  - 0xFFFF mod 0xFE → 0x03.
  - 0x0005 mod 0x07 → 0x05.
  - 0x1234 mod 0x01 → 0x00.
- Zero modulus: product 0x00AB, modulus 0x00 → o_valid 1 edge after accept, result 0x00, o_err=1; next op 0x00AB mod 0x10 → 0x0B, o_err=0.
- Backpressure/ignored input:
  - Hold i_ready=0 for 5 cycles in DONE → result/o_valid stable.
  - Pulse i_valid with a different product during RUN and DONE → ignored, o_ready=0 throughout.
- Reset mid-run: assert rst_in asynchronously (between edges) at bit 7 of 0x1234 mod 0xFB → o_valid/result/o_err 0 immediately, state IDLE; a new op 0x0100 mod 0x0F → 0x01.
- Randomized WIDTH=32: 1000 random product/modulus pairs with random i_ready stalls, scoreboard against a reference % → all match, with latency exactly PROD_WIDTH edges.

Source files
------------

// File: rtl/modexp_pkg.sv
// Shared types for the modular-exponentiation datapath.
package modexp_pkg;
  localparam int DEF_WIDTH = 1024;

  typedef enum logic [1:0] {IDLE, RUN, DONE} red_state_t;
endpackage

// File: rtl/mod_cond_sub.sv
// One restoring step: subtract the modulus when the shifted remainder reaches it.
module mod_cond_sub #(
  parameter int WIDTH = 1024
) (
  input  logic [WIDTH:0]   r_shift,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   r_out
);
  logic [WIDTH:0] m_ext;

  assign m_ext = {1'b0, m};
  assign r_out = (r_shift >= m_ext) ? r_shift - m_ext : r_shift;
endmodule

// File: rtl/modexp_mod_reducer.sv
// Bit-serial restoring reducer: product mod modulus, one product bit per cycle, MSB first.
import modexp_pkg::*;

module modexp_mod_reducer #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PROD_WIDTH = 2*WIDTH,
  parameter int CNT_WIDTH  = $clog2(PROD_WIDTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [PROD_WIDTH-1:0] product_in,
  input  logic [WIDTH-1:0]      modulus_in,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  o_err
);
  red_state_t            state_q, state_d;
  logic [PROD_WIDTH-1:0] shift_q;
  logic [WIDTH-1:0]      m_q;
  logic [WIDTH:0]        rem_q, r_shift, r_next;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [WIDTH-1:0]      result_q;
  logic                  err_q;

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign result  = result_q;
  assign o_err   = err_q;

  // rem_q < m_q always holds, so the shift never loses the top bit
  assign r_shift = (rem_q << 1) | (WIDTH+1)'(shift_q[PROD_WIDTH-1]);

  mod_cond_sub #(.WIDTH(WIDTH)) u_sub (
    .r_shift (r_shift),
    .m       (m_q),
    .r_out   (r_next)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid) state_d = (modulus_in == '0) ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_q  <= '0;
      m_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (i_valid) begin
          shift_q <= product_in;
          m_q     <= modulus_in;
          rem_q   <= '0;
          cnt_q   <= CNT_WIDTH'(PROD_WIDTH-1);
          if (modulus_in == '0) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end
        end
        RUN: begin
          shift_q <= shift_q << 1;
          rem_q   <= r_next;
          if (cnt_q == '0) begin
            result_q <= r_next[WIDTH-1:0];
            err_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
